// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the MEM stage of the RV32I pipeline:
//   - MEM stage FSM state encoding (MEM_IDLE / MEM_WAIT / MEM_HOLD)
//   - funct3 access-size codes (F3_B / F3_H / F3_W / F3_BU / F3_HU)
//   - REGWRITE_OFF (decoder polarity for "no register write")
//   - write_reg_ALU MemtoReg code used for bubbles
//   - access-size decode helper shared by the aligner and the top
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_HOLD = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic       REGWRITE_OFF  = 1'b0;
  localparam logic [1:0] write_reg_ALU = 2'b00;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Source of the next MEM/WB register contents.
  typedef enum logic [2:0] {
    WB_KEEP   = 3'd0,
    WB_BUBBLE = 3'd1,
    WB_PASS   = 3'd2,
    WB_LOAD   = 3'd3,
    WB_BUF    = 3'd4
  } wb_sel_e;

  // Stores only know SB/SH/SW; loads also have the unsigned variants.
  // Anything unrecognised is treated as a full word.
  function automatic size_e access_size(input logic [2:0] funct3,
                                        input logic       is_store);
    size_e sz;
    sz = SIZE_W;
    if (is_store) begin
      case (funct3)
        F3_B:    sz = SIZE_B;
        F3_H:    sz = SIZE_H;
        F3_W:    sz = SIZE_W;
        default: sz = SIZE_W;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: sz = SIZE_B;
        F3_H, F3_HU: sz = SIZE_H;
        F3_W:        sz = SIZE_W;
        default:     sz = SIZE_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align
// Combinational byte-lane steering for stores and sign/zero extraction for
// loads. Used once by the MEM stage; the same extracted load word feeds both
// the direct MEM/WB capture and the hold buffer.
// Ports:
//   funct3     in   3  access size / signedness
//   addr_lo    in   2  effective address bits [1:0]
//   store_data in  32  rs2 value
//   rdata      in  32  word returned by data memory
//   be         out  4  store byte enables
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  extracted, extended load value
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (access_size(funct3, 1'b1))
      SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // funct3[2] marks the unsigned load variants (LBU/LHU).
  assign sign_ext = ~funct3[2];
  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (access_size(funct3, 1'b0))
      SIZE_B:  load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM stage of the 5-stage RV32I pipeline. Launches data-memory accesses for
// the instruction in EX/MEM (_pype2), stalls the front of the pipe while an
// access is outstanding, and owns the MEM/WB register (_pype3, mem_data_pype).
// Optional build macro: MEM_MISALIGN_EXC_EN -- misaligned accesses become a
// bubble plus a misalign_exc pulse / misalign_addr capture instead of being
// force-aligned.
// Ports:
//   clk, rst (async, active-low), keep (hazard hold), nop (bubble inject)
//   *_pype2             EX/MEM bundle inputs
//   dmem_req/we/addr/wdata/be out, dmem_rdata/ack in  data-memory bus
//   mem_stall           freeze for PC/IF/ID/EX
//   *_pype3, mem_data_pype  MEM/WB register outputs
//   misalign_exc, misalign_addr  (only with MEM_MISALIGN_EXC_EN)
module mem_access
  import mem_access_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] BUBBLE_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keep,
  input  logic              nop,
  input  logic [31:0]       PCp4_pype2,
  input  logic [31:0]       ALU_co_pype2,
  input  logic [31:0]       store_data_pype2,
  input  logic [2:0]        funct3_pype2,
  input  logic              MemRead_pype2,
  input  logic              MemWrite_pype2,
  input  logic              RegWrite_pype2,
  input  logic [1:0]        MemtoReg_pype2,
  input  logic [4:0]        WReg_pype2,
  input  logic [1:0]        ID_EX_write_pype2,
  input  logic [1:0]        ID_EX_write_addi_pype2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic [31:0]       PCp4_pype3,
  output logic [31:0]       ALU_co_pype3,
  output logic [31:0]       mem_data_pype,
  output logic [4:0]        WReg_pype3,
  output logic              RegWrite_pype3,
  output logic [1:0]        MemtoReg_pype3,
  output logic [1:0]        ID_EX_write_pype3,
  output logic [1:0]        ID_EX_write_addi_pype3
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic              misalign_exc,
  output logic [31:0]       misalign_addr
`endif
);

  mem_state_e  state, state_nxt;
  wb_sel_e     wb_sel;
  logic        mem_op;
  logic        misalign;
  logic        launch;
  logic        buf_load;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic [31:0] ld_result;
  logic [31:0] hold_buf;

  mem_align u_align (
    .funct3     (funct3_pype2),
    .addr_lo    (ALU_co_pype2[1:0]),
    .store_data (store_data_pype2),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign mem_op = (MemRead_pype2 | MemWrite_pype2) & ~nop;

`ifdef MEM_MISALIGN_EXC_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (access_size(funct3_pype2, MemWrite_pype2))
        SIZE_H:  misalign = ALU_co_pype2[0];
        SIZE_W:  misalign = |ALU_co_pype2[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign launch    = mem_op & ~keep & ~misalign;
  // Stores leave BUBBLE_DATA in mem_data_pype; only loads carry memory data.
  assign ld_result = MemRead_pype2 ? al_load : BUBBLE_DATA;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MEM_IDLE;
    else      state <= state_nxt;
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (launch && !dmem_ack) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ack) state_nxt = keep ? MEM_HOLD : MEM_IDLE;
      MEM_HOLD: if (!keep) state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    buf_load  = 1'b0;
    wb_sel    = WB_KEEP;
    case (state)
      MEM_IDLE: begin
        dmem_req  = launch;
        mem_stall = launch & ~dmem_ack;
        if (keep)                wb_sel = WB_KEEP;
        else if (nop || misalign) wb_sel = WB_BUBBLE;
        else if (mem_op)         wb_sel = dmem_ack ? WB_LOAD : WB_KEEP;
        else                     wb_sel = WB_PASS;
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ack) begin
          // Result arrived while a hazard holds MEM/WB: park it.
          if (keep) buf_load = 1'b1;
          else      wb_sel   = WB_LOAD;
        end
      end
      MEM_HOLD: begin
        mem_stall = keep;
        if (!keep) wb_sel = WB_BUF;
      end
      default: ;
    endcase
    // Reset is asynchronous, so the bus request must drop with it, not a cycle later.
    if (!rst) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  assign dmem_we    = dmem_req & MemWrite_pype2;
  assign dmem_be    = dmem_req ? (MemWrite_pype2 ? al_be : 4'b1111) : 4'b0000;
  assign dmem_addr  = {ALU_co_pype2[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = al_wdata;

  always_ff @(posedge clk) begin
    if (buf_load) hold_buf <= ld_result;
  end

  // ---- MEM/WB register (_pype3) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCp4_pype3             <= '0;
      ALU_co_pype3           <= '0;
      mem_data_pype          <= BUBBLE_DATA;
      WReg_pype3             <= '0;
      RegWrite_pype3         <= REGWRITE_OFF;
      MemtoReg_pype3         <= write_reg_ALU;
      ID_EX_write_pype3      <= '0;
      ID_EX_write_addi_pype3 <= '0;
    end else begin
      case (wb_sel)
        WB_BUBBLE: begin
          PCp4_pype3             <= '0;
          ALU_co_pype3           <= '0;
          mem_data_pype          <= BUBBLE_DATA;
          WReg_pype3             <= '0;
          RegWrite_pype3         <= REGWRITE_OFF;
          MemtoReg_pype3         <= write_reg_ALU;
          ID_EX_write_pype3      <= '0;
          ID_EX_write_addi_pype3 <= '0;
        end
        WB_PASS, WB_LOAD, WB_BUF: begin
          PCp4_pype3             <= PCp4_pype2;
          ALU_co_pype3           <= ALU_co_pype2;
          WReg_pype3             <= WReg_pype2;
          RegWrite_pype3         <= RegWrite_pype2;
          MemtoReg_pype3         <= MemtoReg_pype2;
          ID_EX_write_pype3      <= ID_EX_write_pype2;
          ID_EX_write_addi_pype3 <= ID_EX_write_addi_pype2;
          if (wb_sel == WB_LOAD)     mem_data_pype <= ld_result;
          else if (wb_sel == WB_BUF) mem_data_pype <= hold_buf;
          else                       mem_data_pype <= BUBBLE_DATA;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  // ---- misalignment report ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc <= (state == MEM_IDLE) & misalign & ~keep;
      if ((state == MEM_IDLE) && misalign && !keep) misalign_addr <= ALU_co_pype2;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        keep, nop;
  logic [31:0] PCp4_pype2, ALU_co_pype2, store_data_pype2;
  logic [2:0]  funct3_pype2;
  logic        MemRead_pype2, MemWrite_pype2, RegWrite_pype2;
  logic [1:0]  MemtoReg_pype2;
  logic [4:0]  WReg_pype2;
  logic [1:0]  ID_EX_write_pype2, ID_EX_write_addi_pype2;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic [31:0] PCp4_pype3, ALU_co_pype3, mem_data_pype;
  logic [4:0]  WReg_pype3;
  logic        RegWrite_pype3;
  logic [1:0]  MemtoReg_pype3;
  logic [1:0]  ID_EX_write_pype3, ID_EX_write_addi_pype3;
`ifdef MEM_MISALIGN_EXC_EN
  logic        misalign_exc;
  logic [31:0] misalign_addr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .PCp4_pype2(PCp4_pype2), .ALU_co_pype2(ALU_co_pype2),
    .store_data_pype2(store_data_pype2), .funct3_pype2(funct3_pype2),
    .MemRead_pype2(MemRead_pype2), .MemWrite_pype2(MemWrite_pype2),
    .RegWrite_pype2(RegWrite_pype2), .MemtoReg_pype2(MemtoReg_pype2),
    .WReg_pype2(WReg_pype2), .ID_EX_write_pype2(ID_EX_write_pype2),
    .ID_EX_write_addi_pype2(ID_EX_write_addi_pype2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .PCp4_pype3(PCp4_pype3), .ALU_co_pype3(ALU_co_pype3),
    .mem_data_pype(mem_data_pype), .WReg_pype3(WReg_pype3),
    .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
    .ID_EX_write_pype3(ID_EX_write_pype3),
    .ID_EX_write_addi_pype3(ID_EX_write_addi_pype3)
`ifdef MEM_MISALIGN_EXC_EN
    , .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    keep = 0; nop = 0;
    PCp4_pype2 = 0; ALU_co_pype2 = 0; store_data_pype2 = 0; funct3_pype2 = 0;
    MemRead_pype2 = 0; MemWrite_pype2 = 0; RegWrite_pype2 = 0;
    MemtoReg_pype2 = 0; WReg_pype2 = 0;
    ID_EX_write_pype2 = 0; ID_EX_write_addi_pype2 = 0;
    dmem_rdata = 0; dmem_ack = 0;
  endtask

  initial begin
    // Reset with a pending load on the inputs: nothing may be requested.
    clear_in();
    rst = 0;
    MemRead_pype2 = 1; funct3_pype2 = 3'b010; ALU_co_pype2 = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_regwrite", RegWrite_pype3, 0);
    chk("rst_memdata", mem_data_pype, 32'h0);
    chk("rst_wreg", WReg_pype3, 0);
    chk("rst_pcp4", PCp4_pype3, 0);
    clear_in();
    rst = 1;
    tick();

    // Non-memory pass-through
    PCp4_pype2 = 32'h1004; ALU_co_pype2 = 32'h55; RegWrite_pype2 = 1;
    WReg_pype2 = 7; ID_EX_write_pype2 = 2'b01; ID_EX_write_addi_pype2 = 2'b10;
    #1;
    chk("pass_noreq", dmem_req, 0);
    tick();
    chk("pass_pcp4", PCp4_pype3, 32'h1004);
    chk("pass_alu", ALU_co_pype3, 32'h55);
    chk("pass_wreg", WReg_pype3, 7);
    chk("pass_regwrite", RegWrite_pype3, 1);
    chk("pass_memdata", mem_data_pype, 32'h0);
    chk("pass_tag", ID_EX_write_pype3, 2'b01);
    chk("pass_tag_addi", ID_EX_write_addi_pype3, 2'b10);

    // SB 0xA5 at 0x103, zero-wait
    clear_in();
    MemWrite_pype2 = 1; funct3_pype2 = 3'b000; ALU_co_pype2 = 32'h103;
    store_data_pype2 = 32'h0000_00A5; dmem_ack = 1;
    #1;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_stall", mem_stall, 0);
    tick();
    chk("sb_memdata", mem_data_pype, 32'h0);

    // SH 0xBEEF at 0x002, SW at 0x008
    clear_in();
    MemWrite_pype2 = 1; funct3_pype2 = 3'b001; ALU_co_pype2 = 32'h2;
    store_data_pype2 = 32'h1234BEEF; dmem_ack = 1;
    #1;
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    tick();
    funct3_pype2 = 3'b010; ALU_co_pype2 = 32'h8; store_data_pype2 = 32'hCAFEF00D;
    #1;
    chk("sw_be", dmem_be, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    chk("sw_addr", dmem_addr, 32'h8);
    tick();

    // LB at 0x102, ack on the third cycle
    clear_in();
    MemRead_pype2 = 1; funct3_pype2 = 3'b000; ALU_co_pype2 = 32'h102;
    RegWrite_pype2 = 1; MemtoReg_pype2 = 2'b01; WReg_pype2 = 5;
    #1;
    chk("lb_req", dmem_req, 1);
    chk("lb_we", dmem_we, 0);
    chk("lb_be", dmem_be, 4'b1111);
    chk("lb_stall_c1", mem_stall, 1);
    tick();
    chk("lb_stall_c2", mem_stall, 1);
    chk("lb_req_c2", dmem_req, 1);
    chk("lb_memdata_held", mem_data_pype, 32'h0);
    tick();
    dmem_ack = 1; dmem_rdata = 32'h80FF7F00;
    #1;
    chk("lb_stall_c3", mem_stall, 1);
    tick();
    chk("lb_memdata", mem_data_pype, 32'hFFFFFFFF);
    chk("lb_wreg", WReg_pype3, 5);
    chk("lb_memtoreg", MemtoReg_pype3, 2'b01);
    funct3_pype2 = 3'b100;
    #1;
    chk("lbu_stall", mem_stall, 0);
    tick();
    chk("lbu_memdata", mem_data_pype, 32'h000000FF);

    // LH / LHU at 0x002
    ALU_co_pype2 = 32'h2; funct3_pype2 = 3'b001; dmem_rdata = 32'h80011234;
    tick();
    chk("lh_memdata", mem_data_pype, 32'hFFFF8001);
    funct3_pype2 = 3'b101;
    tick();
    chk("lhu_memdata", mem_data_pype, 32'h00008001);

    // LW whose ack lands while keep is high for two more cycles
    clear_in();
    MemRead_pype2 = 1; funct3_pype2 = 3'b010; ALU_co_pype2 = 32'h40;
    RegWrite_pype2 = 1; MemtoReg_pype2 = 2'b01; WReg_pype2 = 9;
    #1;
    chk("hold_req_c1", dmem_req, 1);
    tick();
    keep = 1; dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("hold_stall_ack", mem_stall, 1);
    tick();
    dmem_ack = 0; dmem_rdata = 32'h0;
    #1;
    chk("hold_req_dropped", dmem_req, 0);
    chk("hold_stall_k1", mem_stall, 1);
    chk("hold_memdata_k1", mem_data_pype, 32'h00008001);
    tick();
    chk("hold_stall_k2", mem_stall, 1);
    chk("hold_memdata_k2", mem_data_pype, 32'h00008001);
    keep = 0;
    #1;
    chk("hold_stall_rel", mem_stall, 0);
    chk("hold_req_rel", dmem_req, 0);
    tick();
    chk("hold_memdata", mem_data_pype, 32'hDEADBEEF);
    chk("hold_wreg", WReg_pype3, 9);

    // nop with MemRead set
    clear_in();
    MemRead_pype2 = 1; nop = 1; RegWrite_pype2 = 1; WReg_pype2 = 4;
    #1;
    chk("nop_req", dmem_req, 0);
    chk("nop_stall", mem_stall, 0);
    tick();
    chk("nop_regwrite", RegWrite_pype3, 0);
    chk("nop_wreg", WReg_pype3, 0);

    // Non-memory op to load MEM/WB, then keep blocks a load launch
    clear_in();
    ALU_co_pype2 = 32'h77; RegWrite_pype2 = 1; WReg_pype2 = 3;
    tick();
    chk("pass2_alu", ALU_co_pype3, 32'h77);
    MemRead_pype2 = 1; funct3_pype2 = 3'b010; ALU_co_pype2 = 32'h80; keep = 1;
    #1;
    chk("keep_noreq", dmem_req, 0);
    tick();
    chk("keep_alu_held", ALU_co_pype3, 32'h77);

    // Reset in the middle of WAIT
    keep = 0;
    tick();
    chk("rstw_req", dmem_req, 1);
    chk("rstw_regwrite_pre", RegWrite_pype3, 1);
    rst = 0;
    #1;
    chk("rstw_req_drop", dmem_req, 0);
    chk("rstw_stall", mem_stall, 0);
    chk("rstw_regwrite", RegWrite_pype3, 0);
    chk("rstw_wreg", WReg_pype3, 0);
    chk("rstw_alu", ALU_co_pype3, 32'h0);
    clear_in();
    rst = 1;
    tick();

    // Misaligned word load at 0x201
    clear_in();
    MemRead_pype2 = 1; funct3_pype2 = 3'b010; ALU_co_pype2 = 32'h201;
    RegWrite_pype2 = 1; WReg_pype2 = 2; MemtoReg_pype2 = 2'b01;
`ifdef MEM_MISALIGN_EXC_EN
    #1;
    chk("mis_noreq", dmem_req, 0);
    chk("mis_nostall", mem_stall, 0);
    tick();
    chk("mis_exc", misalign_exc, 1);
    chk("mis_addr", misalign_addr, 32'h201);
    chk("mis_bubble", RegWrite_pype3, 0);
    clear_in();
    tick();
    chk("mis_exc_pulse", misalign_exc, 0);
    chk("mis_addr_held", misalign_addr, 32'h201);
`else
    dmem_ack = 1; dmem_rdata = 32'h11223344;
    #1;
    chk("mis_addr", dmem_addr, 32'h200);
    chk("mis_be", dmem_be, 4'b1111);
    tick();
    chk("mis_memdata", mem_data_pype, 32'h11223344);
    chk("mis_regwrite", RegWrite_pype3, 1);
`endif

    clear_in();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access (MEM) stage of the 5-stage RV32I pipeline, between execute and writeback.
- Consumes the EX/MEM (`_pype2`) bundle and drives the data-memory req/ack bus.
- Performs store byte-lane steering and load sign/zero extension.
- Owns the MEM/WB pipeline register (`_pype3` outputs plus `mem_data_pype`) that writeback reads, and raises `mem_stall` while a memory access is outstanding.

Parameters:
- ADDR_W, 32: width of `dmem_addr`; upper ALU bits beyond ADDR_W are dropped.
- BUBBLE_DATA, 32'h0000_0000: value loaded into `mem_data_pype` on bubbles and non-load instructions.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- keep  in  1  hazard hold; MEM/WB register holds its value and no new access is launched.
- nop  in  1  inject a bubble into MEM/WB.
- PCp4_pype2  in  32  PC+4 of the instruction.
- ALU_co_pype2  in  32  ALU result / effective address.
- store_data_pype2  in  32  rs2 value for stores.
- funct3_pype2  in  3  access size / sign.
- MemRead_pype2  in  1  load.
- MemWrite_pype2  in  1  store.
- RegWrite_pype2  in  1  passed through unchanged, with the decoder's polarity.
- MemtoReg_pype2  in  2  writeback select.
- WReg_pype2  in  5  destination register.
- ID_EX_write_pype2, ID_EX_write_addi_pype2  in  2 each  forwarding tags.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_wdata  out  32  replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read word.
- dmem_ack  in  1  access complete; rdata valid.
- mem_stall  out  1  freeze PC/IF/ID/EX.
- PCp4_pype3, ALU_co_pype3, mem_data_pype  out  32  MEM/WB data.
- WReg_pype3  out  5.
- RegWrite_pype3  out  1.
- MemtoReg_pype3  out  2.
- ID_EX_write_pype3, ID_EX_write_addi_pype3  out  2.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All `_pype3` outputs take bubble values: RegWrite = `REGWRITE_OFF`, WReg 0, MemtoReg `write_reg_ALU`, PCp4/ALU_co 0, mem_data_pype = BUBBLE_DATA, forwarding tags 0.
  - dmem_req, dmem_we, dmem_be, mem_stall all 0.
- A memory op is MemRead|MemWrite with nop=0; at most one of the two is set.
- FSM states:
  - IDLE: if memory op and keep=0, drive dmem_req=1 combinationally.
    - ack in the same cycle: capture the result into MEM/WB at the edge, stay IDLE (zero-wait access).
    - no ack: go to WAIT.
  - WAIT: dmem_req held at 1 with stable addr/we/be/wdata (upstream is frozen by mem_stall). When dmem_ack arrives:
    - keep=0: capture into MEM/WB, go to IDLE.
    - keep=1: latch the extended load data into a hold buffer, drop req, go to HOLD.
  - HOLD: no request; on the first cycle with keep=0, load MEM/WB from the hold buffer, go to IDLE.
- mem_stall = (IDLE & req & ~ack) | WAIT | (HOLD & keep).
- Non-memory instruction with keep=0: MEM/WB loads the pass-through fields after 1 cycle of latency; mem_data_pype = BUBBLE_DATA.
- nop=1 and keep=0: MEM/WB loads bubble values, no request. keep has priority over nop.
- Store lanes (funct3):
  - 000 SB: be = 1<<a[1:0], wdata = {4{d[7:0]}}.
  - 001 SH: be = a[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - 010 SW: be = 1111.
  - Loads drive be = 1111, we = 0.
- Load extract (funct3):
  - 000 LB / 100 LBU: byte a[1:0], sign- / zero-extended.
  - 001 LH / 101 LHU: half a[1], sign- / zero-extended.
  - 010 LW: full word.
  - Other funct3 values behave as LW / SW.
- Misaligned (LH/SH with a[0]=1; LW/SW with a[1:0]≠0), without the optional feature: low address bits are ignored as above (half uses a[1], word uses the whole word).
- Reset mid-WAIT: req drops immediately; the memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- With it defined, a misaligned op:
  - issues no dmem_req and does not assert mem_stall;
  - MEM/WB loads a bubble;
  - adds outputs `misalign_exc` (1-cycle pulse) and `misalign_addr` (32, holds the faulting address until the next fault; reset 0).
- Without it: ports absent, forced-alignment behaviour as above.

Decomposition:
- define.v additions:
  - FSM state encodings MEM_IDLE/MEM_WAIT/MEM_HOLD;
  - funct3 codes F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - `REGWRITE_OFF`;
  - reuse existing `write_reg_*` MemtoReg codes.
- One combinational sub-module `mem_align`: (funct3, addr[1:0], store data, rdata) → (be, wdata, extended load data). It is shared by the request path and the hold-buffer path.

Test Plan:
- SB x=0x000000A5 at addr 0x103, zero-wait ack → be=1000, wdata=0xA5A5A5A5, dmem_addr=0x100, no mem_stall.
- LB addr 0x102, rdata 0x80FF7F00, ack after 3 cycles → mem_stall high for 3 cycles, mem_data_pype=0xFFFFFFFF; LBU same → 0x000000FF.
- LH addr 0x002, rdata 0x8001_1234 → 0xFFFF8001; LHU → 0x00008001.
- LW ack arrives while keep=1 for 2 more cycles → HOLD, req dropped, MEM/WB unchanged until keep falls, then mem_data_pype=rdata.
- nop=1 with MemRead=1 → no dmem_req, RegWrite_pype3=`REGWRITE_OFF`. rst low mid-WAIT → req=0 and bubble outputs asynchronously.
- With MEM_MISALIGN_EXC_EN: LW at 0x201 → no req, misalign_exc pulse, misalign_addr=0x201. Without it → dmem_addr=0x200, full word returned.
